// File: rtl/reaction_timer_if.sv
// Result channel of the reaction timer.
// Carries the measured reaction count and its qualifiers from the timer
// (master) to the consuming game logic (slave) over a valid/ready handshake.
//   result        N-bit reaction count, all-ones on false start or timeout
//   result_valid  result available, held until accepted
//   result_ready  consumer accepts when high together with result_valid
//   false_start   qualifies the current result: press seen before/with go
//   timeout       qualifies the current result: count saturated, no press
interface reaction_timer_if #(
    parameter int N = 16
);
    logic [N-1:0] result;
    logic         result_valid;
    logic         result_ready;
    logic         false_start;
    logic         timeout;

    modport master (
        output result,
        output result_valid,
        output false_start,
        output timeout,
        input  result_ready
    );

    modport slave (
        input  result,
        input  result_valid,
        input  false_start,
        input  timeout,
        output result_ready
    );
endinterface

// File: rtl/reaction_timer.sv
// Reaction timer: once armed it waits for the countdown's zero level (go),
// then counts prescaled ticks until the first rising edge of press and
// hands the count over the result channel. A press before or with go is
// reported as a false start, and a saturated count as a timeout.
// Ports:
//   clk      system clock, rising edge
//   n_reset  asynchronous active-low reset
//   arm      one-cycle trial request, honoured only when idle
//   go       countdown reached zero (level)
//   press    button level, already synchronised to clk
//   busy     high whenever a trial is in progress or a result is pending
//   res      result channel (master side)
module reaction_timer #(
    parameter int N        = 16,
    parameter int PRESCALE = 1000
) (
    input  logic               clk,
    input  logic               n_reset,
    input  logic               arm,
    input  logic               go,
    input  logic               press,
    output logic               busy,
    reaction_timer_if.master   res
);

    localparam int              PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]   PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [N-1:0]    CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_GO,
        TIMING,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;

    logic          press_q;
    logic          rise;
    logic          wrap;
    logic          saturate;
    logic          accept;
    logic [PW-1:0] presc;
    logic [N-1:0]  count;

    logic [N-1:0]  result_d;
    logic          false_start_d;
    logic          timeout_d;

    // Only rising edges count, so a button held since before the trial
    // never registers until it has been released and pressed again.
    assign rise     = press & ~press_q;
    assign wrap     = (presc == PRE_LAST);
    assign saturate = wrap && (count == CNT_MAX);
    assign accept   = res.result_valid & res.result_ready;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (arm) begin
                    state_next = WAIT_GO;
                end
            end
            WAIT_GO: begin
                // A rise checked before go makes a coincident press a false start.
                if (rise) begin
                    state_next = DONE;
                end else if (go) begin
                    state_next = TIMING;
                end
            end
            TIMING: begin
                if (rise || saturate) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (accept) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        result_d      = res.result;
        false_start_d = res.false_start;
        timeout_d     = res.timeout;
        case (state)
            WAIT_GO: begin
                if (rise) begin
                    result_d      = '1;
                    false_start_d = 1'b1;
                    timeout_d     = 1'b0;
                end
            end
            TIMING: begin
                // Rise takes priority over a coincident wrap and reports the
                // count as it stood before the increment.
                if (rise) begin
                    result_d      = count;
                    false_start_d = 1'b0;
                    timeout_d     = 1'b0;
                end else if (saturate) begin
                    result_d      = '1;
                    false_start_d = 1'b0;
                    timeout_d     = 1'b1;
                end
            end
            DONE: begin
                // result keeps its last value after hand-off; only the
                // qualifiers are cleared.
                if (accept) begin
                    false_start_d = 1'b0;
                    timeout_d     = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            press_q          <= 1'b0;
            res.result       <= '0;
            res.false_start  <= 1'b0;
            res.timeout      <= 1'b0;
            res.result_valid <= 1'b0;
            busy             <= 1'b0;
        end else begin
            press_q          <= press;
            res.result       <= result_d;
            res.false_start  <= false_start_d;
            res.timeout      <= timeout_d;
            res.result_valid <= (state_next == DONE);
            busy             <= (state_next != IDLE);
        end
    end

    // Prescaler and count are held at zero while waiting so that the first
    // TIMING cycle starts from a clean zero.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            presc <= '0;
            count <= '0;
        end else if (state == WAIT_GO) begin
            presc <= '0;
            count <= '0;
        end else if (state == TIMING) begin
            if (wrap) begin
                presc <= '0;
                if (count != CNT_MAX) begin
                    count <= count + 1'b1;
                end
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reaction_timer.sv
// Testbench for reaction_timer: two instances (N=8/PRESCALE=4 and
// N=4/PRESCALE=2). Stimulus pushes expected results into a per-instance
// queue; a monitor pops and compares on each accepted handshake.
module tb_reaction_timer;

    typedef struct packed {
        logic [7:0] res;
        logic       fs;
        logic       to;
    } exp_t;

    logic clk = 1'b0;
    logic n_reset = 1'b0;

    logic arm0 = 1'b0, go0 = 1'b0, press0 = 1'b0, busy0;
    logic arm1 = 1'b0, go1 = 1'b0, press1 = 1'b0, busy1;

    int checks = 0;
    int errors = 0;

    exp_t q0[$];
    exp_t q1[$];

    reaction_timer_if #(.N(8)) ifc0 ();
    reaction_timer_if #(.N(4)) ifc1 ();

    reaction_timer #(.N(8), .PRESCALE(4)) dut0 (
        .clk     (clk),
        .n_reset (n_reset),
        .arm     (arm0),
        .go      (go0),
        .press   (press0),
        .busy    (busy0),
        .res     (ifc0)
    );

    reaction_timer #(.N(4), .PRESCALE(2)) dut1 (
        .clk     (clk),
        .n_reset (n_reset),
        .arm     (arm1),
        .go      (go1),
        .press   (press1),
        .busy    (busy1),
        .res     (ifc1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (n_reset && ifc0.result_valid && ifc0.result_ready) begin
            if (q0.size() == 0) begin
                chk("dut0_unexpected_result", 32'(ifc0.result), 32'hDEAD);
            end else begin
                exp_t e;
                e = q0.pop_front();
                chk("dut0_result", 32'(ifc0.result), 32'(e.res));
                chk("dut0_false_start", 32'(ifc0.false_start), 32'(e.fs));
                chk("dut0_timeout", 32'(ifc0.timeout), 32'(e.to));
            end
        end
    end

    always @(negedge clk) begin
        if (n_reset && ifc1.result_valid && ifc1.result_ready) begin
            if (q1.size() == 0) begin
                chk("dut1_unexpected_result", 32'(ifc1.result), 32'hDEAD);
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("dut1_result", 32'(ifc1.result), 32'(e.res));
                chk("dut1_false_start", 32'(ifc1.false_start), 32'(e.fs));
                chk("dut1_timeout", 32'(ifc1.timeout), 32'(e.to));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ifc0.result_ready = 1'b1;
        ifc1.result_ready = 1'b1;

        // Reset state
        repeat (2) tick();
        chk("rst_result", 32'(ifc0.result), 0);
        chk("rst_valid", 32'(ifc0.result_valid), 0);
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_busy1", 32'(busy1), 0);
        n_reset = 1'b1;
        tick();

        // Normal trial, rise at k=10 -> 2
        arm0 = 1'b1; tick(); arm0 = 1'b0;
        chk("arm_busy", 32'(busy0), 1);
        go0 = 1'b1; tick();
        repeat (10) tick();
        press0 = 1'b1; q0.push_back('{8'd2, 1'b0, 1'b0}); tick();
        chk("t1_valid", 32'(ifc0.result_valid), 1);
        chk("t1_result", 32'(ifc0.result), 2);
        press0 = 1'b0; go0 = 1'b0; tick();
        chk("t1_idle_valid", 32'(ifc0.result_valid), 0);
        chk("t1_idle_busy", 32'(busy0), 0);

        // False start: rise before go, go afterwards ignored
        arm0 = 1'b1; tick(); arm0 = 1'b0;
        press0 = 1'b1; q0.push_back('{8'hFF, 1'b1, 1'b0}); tick();
        chk("fs1_valid", 32'(ifc0.result_valid), 1);
        chk("fs1_flag", 32'(ifc0.false_start), 1);
        go0 = 1'b1; tick(); tick();
        chk("fs1_busy_after", 32'(busy0), 0);
        chk("fs1_flag_cleared", 32'(ifc0.false_start), 0);
        go0 = 1'b0; press0 = 1'b0; tick();

        // False start: rise coincident with go
        arm0 = 1'b1; tick(); arm0 = 1'b0;
        press0 = 1'b1; go0 = 1'b1; q0.push_back('{8'hFF, 1'b1, 1'b0}); tick();
        chk("fs2_flag", 32'(ifc0.false_start), 1);
        chk("fs2_result", 32'(ifc0.result), 32'hFF);
        go0 = 1'b0; press0 = 1'b0; tick(); tick();

        // Press held through arm and go, re-pressed at k=9 -> 2
        press0 = 1'b1; tick();
        arm0 = 1'b1; tick(); arm0 = 1'b0;
        go0 = 1'b1; tick();
        repeat (3) tick();
        press0 = 1'b0;
        repeat (6) tick();
        chk("held_no_result", 32'(ifc0.result_valid), 0);
        press0 = 1'b1; q0.push_back('{8'd2, 1'b0, 1'b0}); tick();
        chk("held_valid", 32'(ifc0.result_valid), 1);
        press0 = 1'b0; go0 = 1'b0; tick();

        // go dropped after one cycle; rise on wrap cycle k=7 -> 1
        arm0 = 1'b1; tick(); arm0 = 1'b0;
        go0 = 1'b1; tick(); go0 = 1'b0;
        repeat (7) tick();
        press0 = 1'b1; q0.push_back('{8'd1, 1'b0, 1'b0}); tick();
        chk("wrap_result", 32'(ifc0.result), 1);
        press0 = 1'b0; tick();

        // Back-pressure: ready low 5 cycles, arm pulsed meanwhile
        ifc0.result_ready = 1'b0;
        arm0 = 1'b1; tick(); arm0 = 1'b0;
        go0 = 1'b1; tick();
        repeat (6) tick();
        press0 = 1'b1; q0.push_back('{8'd1, 1'b0, 1'b0}); tick();
        press0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            arm0 = (i == 2);
            chk("bp_valid", 32'(ifc0.result_valid), 1);
            chk("bp_result", 32'(ifc0.result), 1);
            tick();
        end
        arm0 = 1'b0;
        ifc0.result_ready = 1'b1; tick();
        chk("bp_accept_valid", 32'(ifc0.result_valid), 0);
        chk("bp_accept_busy", 32'(busy0), 0);
        arm0 = 1'b1; tick(); arm0 = 1'b0;
        chk("bp_rearm_busy", 32'(busy0), 1);
        tick();
        repeat (5) tick();
        press0 = 1'b1; q0.push_back('{8'd1, 1'b0, 1'b0}); tick();
        chk("bp_new_valid", 32'(ifc0.result_valid), 1);
        press0 = 1'b0; go0 = 1'b0; tick();

        // Timeout on dut1 (N=4, PRESCALE=2) at k=31
        arm1 = 1'b1; tick(); arm1 = 1'b0;
        go1 = 1'b1; tick();
        repeat (30) tick();
        chk("to_not_yet", 32'(ifc1.result_valid), 0);
        tick();
        q1.push_back('{8'h0F, 1'b0, 1'b1}); tick();
        chk("to_valid", 32'(ifc1.result_valid), 1);
        chk("to_flag", 32'(ifc1.timeout), 1);
        press1 = 1'b1; tick();
        repeat (3) tick();
        chk("to_after_busy", 32'(busy1), 0);
        press1 = 1'b0; go1 = 1'b0; tick();

        // Reset mid-TIMING aborts; go/press without arm ignored
        arm0 = 1'b1; tick(); arm0 = 1'b0;
        go0 = 1'b1; tick();
        repeat (5) tick();
        n_reset = 1'b0; #1;
        chk("mid_rst_result", 32'(ifc0.result), 0);
        chk("mid_rst_valid", 32'(ifc0.result_valid), 0);
        chk("mid_rst_busy", 32'(busy0), 0);
        chk("mid_rst_flags", 32'({ifc0.false_start, ifc0.timeout}), 0);
        tick();
        n_reset = 1'b1; tick();
        for (int i = 0; i < 6; i++) begin
            press0 = i[0];
            tick();
        end
        chk("post_rst_busy", 32'(busy0), 0);
        chk("post_rst_valid", 32'(ifc0.result_valid), 0);
        press0 = 1'b0; go0 = 1'b0;
        repeat (3) tick();

        chk("q0_drained", 32'(q0.size()), 0);
        chk("q1_drained", 32'(q1.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
